tourn_table_sched: RTL and testbench

TOURN_TABLE_SCHED -- requirements
Module: tourn_table_sched

---
 rtl/tourn_pkg.sv | 29 ++
 rtl/tourn_upd_fifo.sv | 52 +++++
 rtl/tourn_table_sched.sv | 156 +++++++++++++++
 tb/tb_tourn_table_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tourn_pkg.sv
// Shared types for the tournament predictor table scheduler.
// Holds FSM states, counter type and saturating update helper.
package tourn_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_WR = 2'd2
  } state_e;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_INIT = 2'b01;

  function automatic ctr_t ctr_sat(
    input ctr_t c,
    input logic taken
  );
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'd1;
    end else begin
      if (c != 2'b00) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tourn_upd_fifo.sv
// Two-entry update queue between branch resolution and the table.
// Push is only legal when not full; pop only when valid.
module tourn_upd_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic               wptr_q;
  logic               rptr_q;
  logic [1:0]         cnt_q;
  logic [1:0]         cnt_d;
  logic               push;
  logic               pop;

  assign full_o = cnt_q[1];
  assign v_o    = |cnt_q;
  assign data_o = mem_q[rptr_q];
  assign push   = v_i & ~full_o;
  assign pop    = yumi_i & v_o;

  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop) cnt_d = cnt_q + 2'd1;
    if (pop & ~push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/tourn_table_sched.sv
// Arbitrates one single-port 2-bit counter table between predict
// reads, queued read-modify-write updates and the reset init sweep.
module tourn_table_sched
  import tourn_pkg::*;
#(
  parameter int         idx_width_p   = 10,
  parameter int         stall_limit_p = 4,
  parameter logic [1:0] init_val_p    = CTR_INIT
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   r_v_i,
  input  logic [idx_width_p-1:0] r_addr_i,
  output logic                   r_ready_o,
  output logic                   pred_v_o,
  output logic                   pred_o,
  input  logic                   w_v_i,
  input  logic [idx_width_p-1:0] w_idx_i,
  input  logic                   w_taken_i,
  output logic                   w_yumi_o,
  output logic                   init_done_o,
  output logic                   sram_v_o,
  output logic                   sram_w_o,
  output logic [idx_width_p-1:0] sram_addr_o,
  output logic [1:0]             sram_data_o,
  input  logic [1:0]             sram_data_i
);

  localparam int SW = $clog2(stall_limit_p + 2);
  localparam logic [SW-1:0] StallLim = SW'(stall_limit_p);
  localparam int FW = idx_width_p + 1;

  state_e                 state_q, state_d;
  logic [idx_width_p-1:0] sweep_q, sweep_d;
  logic                   init_done_q, init_done_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [idx_width_p-1:0] upd_idx_q, upd_idx_d;
  logic                   upd_tkn_q, upd_tkn_d;
  logic                   pred_v_q;

  logic                   fifo_full;
  logic                   fifo_v;
  logic [FW-1:0]          fifo_head;
  logic                   grant;
  logic                   issue;
  logic                   yumi;

  logic                   s_v;
  logic                   s_w;
  logic [idx_width_p-1:0] s_addr;
  ctr_t                   s_data;

  assign yumi = w_v_i & init_done_q & ~fifo_full;

  // Reads win until an update has been starved stall_limit_p times.
  assign grant = (state_q == ST_IDLE) & r_v_i
               & (starve_q < StallLim);
  assign issue = (state_q == ST_IDLE) & ~grant & fifo_v;

  tourn_upd_fifo #(
    .width_p(FW)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (yumi),
    .data_i   ({w_idx_i, w_taken_i}),
    .full_o   (fifo_full),
    .v_o      (fifo_v),
    .data_o   (fifo_head),
    .yumi_i   (issue)
  );

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    upd_idx_d   = upd_idx_q;
    upd_tkn_d   = upd_tkn_q;
    s_v         = 1'b0;
    s_w         = 1'b0;
    s_addr      = '0;
    s_data      = '0;
    unique case (state_q)
      ST_INIT: begin
        s_v     = 1'b1;
        s_w     = 1'b1;
        s_addr  = sweep_q;
        s_data  = init_val_p;
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (grant) begin
          s_v    = 1'b1;
          s_addr = r_addr_i;
        end else if (issue) begin
          s_v       = 1'b1;
          s_addr    = fifo_head[FW-1:1];
          upd_idx_d = fifo_head[FW-1:1];
          upd_tkn_d = fifo_head[0];
          state_d   = ST_UPD_WR;
        end
      end
      ST_UPD_WR: begin
        s_v     = 1'b1;
        s_w     = 1'b1;
        s_addr  = upd_idx_q;
        s_data  = ctr_sat(sram_data_i, upd_tkn_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (issue || !fifo_v) starve_d = '0;
    else if (grant)       starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      starve_q    <= '0;
      upd_idx_q   <= '0;
      upd_tkn_q   <= 1'b0;
      pred_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      starve_q    <= starve_d;
      upd_idx_q   <= upd_idx_d;
      upd_tkn_q   <= upd_tkn_d;
      pred_v_q    <= grant;
    end
  end

  // The table port is gated so it goes quiet the moment reset asserts.
  assign sram_v_o    = s_v & reset_n_i;
  assign sram_w_o    = s_w & reset_n_i;
  assign sram_addr_o = reset_n_i ? s_addr : '0;
  assign sram_data_o = reset_n_i ? s_data : '0;

  assign r_ready_o   = grant;
  assign w_yumi_o    = yumi;
  assign init_done_o = init_done_q;
  assign pred_v_o    = pred_v_q;
  assign pred_o      = pred_v_q & sram_data_i[1];

endmodule

// File: tb/tb_tourn_table_sched.sv
// Directed bench for tourn_table_sched with a behavioural
// single-port table of 16 entries.
module tb_tourn_table_sched;

  logic       clk;
  logic       rst_n;
  logic       r_v;
  logic [3:0] r_addr;
  logic       r_ready;
  logic       pred_v;
  logic       pred;
  logic       w_v;
  logic [3:0] w_idx;
  logic       w_taken;
  logic       w_yumi;
  logic       init_done;
  logic       s_v;
  logic       s_w;
  logic [3:0] s_addr;
  logic [1:0] s_wdata;
  logic [1:0] s_rdata;

  logic [1:0] mem [16];

  int errors = 0;
  int checks = 0;

  tourn_table_sched #(
    .idx_width_p  (4),
    .stall_limit_p(4),
    .init_val_p   (2'b01)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .r_v_i      (r_v),
    .r_addr_i   (r_addr),
    .r_ready_o  (r_ready),
    .pred_v_o   (pred_v),
    .pred_o     (pred),
    .w_v_i      (w_v),
    .w_idx_i    (w_idx),
    .w_taken_i  (w_taken),
    .w_yumi_o   (w_yumi),
    .init_done_o(init_done),
    .sram_v_o   (s_v),
    .sram_w_o   (s_w),
    .sram_addr_o(s_addr),
    .sram_data_o(s_wdata),
    .sram_data_i(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_v) begin
      if (s_w) mem[s_addr] <= s_wdata;
      else     s_rdata <= mem[s_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [3:0] ra,
                       input logic wv, input logic [3:0] wi,
                       input logic wt);
    @(negedge clk);
    r_v     = rv;
    r_addr  = ra;
    w_v     = wv;
    w_idx   = wi;
    w_taken = wt;
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_sram_v"}, int'(s_v), 0);
    chk({nm, "_sram_w"}, int'(s_w), 0);
    chk({nm, "_addr"}, int'(s_addr), 0);
    chk({nm, "_wdata"}, int'(s_wdata), 0);
    chk({nm, "_r_ready"}, int'(r_ready), 0);
    chk({nm, "_w_yumi"}, int'(w_yumi), 0);
    chk({nm, "_init_done"}, int'(init_done), 0);
    chk({nm, "_pred_v"}, int'(pred_v), 0);
    chk({nm, "_pred"}, int'(pred), 0);
  endtask

  typedef struct {
    logic       rv;
    logic [3:0] ra;
    logic       wv;
    logic [3:0] wi;
    logic       wt;
    logic       rr;
    logic       yu;
    logic       sv;
    logic       sw;
    logic [3:0] sa;
    logic [1:0] sd;
    logic       pv;
    logic       p;
  } vec_t;

  vec_t vt [17];
  logic [6:0] starve_pat;

  initial begin
    rst_n   = 1'b0;
    r_v     = 1'b0;
    r_addr  = '0;
    w_v     = 1'b0;
    w_idx   = '0;
    w_taken = 1'b0;
    s_rdata = '0;

    // rv ra wv wi wt | rr yu sv sw sa sd pv p
    vt[0]  = '{0, 0, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 1, 3, 1, 0, 1, 1, 0, 3, 0, 0, 0};
    vt[2]  = '{0, 0, 1, 3, 1, 0, 1, 1, 1, 3, 2, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 3, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 3, 0, 0};
    vt[7]  = '{1, 3, 0, 0, 0, 1, 0, 1, 0, 3, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vt[9]  = '{0, 0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vt[10] = '{0, 0, 1, 5, 0, 0, 1, 1, 0, 5, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0};
    vt[14] = '{1, 5, 0, 0, 0, 1, 0, 1, 0, 5, 0, 0, 0};
    vt[15] = '{1, 3, 0, 0, 0, 1, 0, 1, 0, 3, 0, 1, 0};
    vt[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    // Reset state, with requests pending.
    drive(1, 4'd2, 1, 4'd4, 1);
    chk_quiet("rst");

    // Init sweep: 16 writes, then init_done.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("sweep%0d_v", k), int'(s_v & s_w), 1);
      chk($sformatf("sweep%0d_addr", k), int'(s_addr), k);
      chk($sformatf("sweep%0d_data", k), int'(s_wdata), 1);
      chk($sformatf("sweep%0d_done", k), int'(init_done), 0);
      chk($sformatf("sweep%0d_rr", k), int'(r_ready), 0);
      chk($sformatf("sweep%0d_yumi", k), int'(w_yumi), 0);
    end
    drive(0, 0, 0, 0, 0);
    chk("init_done", int'(init_done), 1);
    chk("idle_quiet", int'(s_v), 0);

    // Counter increments, saturation, floor and predictions.
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rv, vt[i].ra, vt[i].wv, vt[i].wi, vt[i].wt);
      chk($sformatf("v%0d_rr", i), int'(r_ready), int'(vt[i].rr));
      chk($sformatf("v%0d_yumi", i), int'(w_yumi), int'(vt[i].yu));
      chk($sformatf("v%0d_sv", i), int'(s_v), int'(vt[i].sv));
      chk($sformatf("v%0d_sw", i), int'(s_w), int'(vt[i].sw));
      if (vt[i].sv)
        chk($sformatf("v%0d_addr", i), int'(s_addr), int'(vt[i].sa));
      if (vt[i].sw)
        chk($sformatf("v%0d_data", i), int'(s_wdata), int'(vt[i].sd));
      chk($sformatf("v%0d_pv", i), int'(pred_v), int'(vt[i].pv));
      chk($sformatf("v%0d_p", i), int'(pred), int'(vt[i].p));
    end

    // Starvation limit: 4 grants, 2 update cycles, grants resume.
    drive(1, 4'd0, 1, 4'd7, 1);
    chk("starve_enq_rr", int'(r_ready), 1);
    chk("starve_enq_yumi", int'(w_yumi), 1);
    starve_pat = 7'b1001111;
    for (int i = 0; i < 7; i++) begin
      drive(1, 4'd0, 0, 0, 0);
      chk($sformatf("starve%0d_rr", i), int'(r_ready),
          int'(starve_pat[i]));
      if (i == 5) begin
        chk("starve_wr_addr", int'(s_addr), 7);
        chk("starve_wr_data", int'(s_wdata), 2);
      end
    end
    drive(0, 0, 0, 0, 0);

    // Full FIFO with a pop in the same cycle: no bypass.
    drive(1, 4'd1, 1, 4'd8, 1);
    chk("full_a_yumi", int'(w_yumi), 1);
    drive(1, 4'd1, 1, 4'd9, 1);
    chk("full_b_yumi", int'(w_yumi), 1);
    drive(1, 4'd1, 1, 4'd10, 1);
    chk("full_c_yumi", int'(w_yumi), 0);
    chk("full_c_rr", int'(r_ready), 1);
    drive(1, 4'd1, 1, 4'd10, 1);
    chk("full_d_rr", int'(r_ready), 1);
    drive(1, 4'd1, 1, 4'd10, 1);
    chk("full_e_rr", int'(r_ready), 1);
    drive(1, 4'd1, 1, 4'd10, 1);
    chk("full_pop_yumi", int'(w_yumi), 0);
    chk("full_pop_rr", int'(r_ready), 0);
    chk("full_pop_rd", int'(s_v & ~s_w), 1);
    chk("full_pop_addr", int'(s_addr), 8);
    drive(1, 4'd1, 1, 4'd10, 1);
    chk("full_next_yumi", int'(w_yumi), 1);
    chk("full_next_wr", int'(s_v & s_w), 1);
    chk("full_next_addr", int'(s_addr), 8);
    chk("full_next_data", int'(s_wdata), 2);
    drive(0, 0, 0, 0, 0);
    chk("drain_rd9", int'(s_addr), 9);
    drive(0, 0, 0, 0, 0);
    chk("drain_wr9", int'(s_wdata), 2);
    drive(0, 0, 0, 0, 0);
    chk("drain_rd10", int'(s_addr), 10);
    drive(0, 0, 0, 0, 0);
    chk("drain_wr10", int'(s_v & s_w), 1);
    chk("drain_wr10_data", int'(s_wdata), 2);
    drive(0, 0, 0, 0, 0);
    chk("drain_idle", int'(s_v), 0);

    // Reset mid-sweep at address 9.
    drive(1, 4'd2, 1, 4'd4, 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_addr9", int'(s_addr), 9);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst3");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_addr", int'(s_addr), 0);
    chk("restart_wr", int'(s_v & s_w), 1);
    @(negedge clk);
    #1;
    chk("restart_addr1", int'(s_addr), 1);
    chk("restart_done", int'(init_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
